// File: rtl/serial_four_bit_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB-first, behind a start/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             load, step;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [WIDTH-2:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic             carry, carry_nxt, bit_s;
  logic [CW-1:0]    cnt;
  logic             last;

  assign bit_s     = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_nxt = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  assign psum_nxt  = {bit_s, psum};
  assign last      = (cnt == CW'(WIDTH - 1));

  // Handshake outputs decode the state register only; no path from inputs.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      sh_a  <= a;
      sh_b  <= b;
      carry <= cin;
      psum  <= '0;
      cnt   <= '0;
    end else if (step) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      carry <= carry_nxt;
      psum  <= psum_nxt[WIDTH-1:1];
      cnt   <= cnt + 1'b1;
      // Only the completed word is published; partial sums stay internal.
      if (last) begin
        sum  <= psum_nxt;
        cout <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ carry_nxt;
`endif
      end
    end
  end

endmodule
